// File: rtl/skeleton_trace_pkg.sv
// Shared constants and entry packing for the skeleton output trace capture.
// An entry is {wrap, timestamp, value} with value in the LSBs.
package skeleton_trace_pkg;

  localparam int SKEL_W         = 3;
  localparam int SKEL_TS_W      = 16;
  localparam int SKEL_VALUE_LSB = 0;
  localparam int SKEL_TS_LSB    = SKEL_VALUE_LSB + SKEL_W;
  localparam int SKEL_WRAP_BIT  = SKEL_TS_LSB + SKEL_TS_W;
  localparam int SKEL_ENTRY_W   = SKEL_WRAP_BIT + 1;
  localparam int PACK_MAX_W     = 128;

  // Widths are passed as constants so non-default instances can share this helper.
  function automatic logic [PACK_MAX_W-1:0] pack_entry(
    input logic        wrap,
    input logic [63:0] ts,
    input logic [63:0] value,
    input int          w,
    input int          ts_w
  );
    return (PACK_MAX_W'(value) << SKEL_VALUE_LSB)
         | (PACK_MAX_W'(ts) << (SKEL_VALUE_LSB + w))
         | (PACK_MAX_W'(wrap) << (SKEL_VALUE_LSB + w + ts_w));
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Generic first-word-fall-through circular buffer with synchronous flush.
// A push while full is accepted only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));
  assign count    = count_q;
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/skeleton_trace_capture.sv
// Records every change of the skeleton outputs (d, e, f) with a cycle timestamp
// into a small FWFT buffer drained through a valid/ready port.
module skeleton_trace_capture
  import skeleton_trace_pkg::*;
#(
  parameter int W     = SKEL_W,
  parameter int TS_W  = SKEL_TS_W,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clear,
  input  logic [W-1:0]             sample,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [TS_W+W:0]          rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int ENTRY_W = 1 + TS_W + W;

  logic [TS_W-1:0]    ts_q, ts_d;
  logic [W-1:0]       prev_sample_q, prev_sample_d;
  logic               prev_valid_q, prev_valid_d;
  logic               wrap_pending_q, wrap_pending_d;
  logic               overflow_q, overflow_d;
  logic               evt, ts_wraps, pop, push_accepted;
  logic               fifo_empty, fifo_full;
  logic [ENTRY_W-1:0] push_data;

  always_comb begin
    evt           = en && (!prev_valid_q || (sample != prev_sample_q));
    ts_wraps      = en && (ts_q == '1);
    pop           = rd_ready && !fifo_empty;
    push_accepted = evt && (!fifo_full || pop);
    push_data     = ENTRY_W'(pack_entry(wrap_pending_q | ts_wraps, 64'(ts_q),
                                        64'(sample), W, TS_W));
    ts_d          = en ? ts_q + TS_W'(1) : ts_q;
    prev_sample_d = en ? sample : prev_sample_q;
    prev_valid_d  = prev_valid_q | en;
    // A dropped entry keeps the pending wrap so the next stored entry still flags it.
    wrap_pending_d = push_accepted ? 1'b0 : (wrap_pending_q | ts_wraps);
    overflow_d     = overflow_q | (evt && !push_accepted);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      ts_q           <= '0;
      prev_sample_q  <= '0;
      prev_valid_q   <= 1'b0;
      wrap_pending_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      ts_q           <= ts_d;
      prev_sample_q  <= prev_sample_d;
      prev_valid_q   <= prev_valid_d;
      wrap_pending_q <= wrap_pending_d;
      overflow_q     <= overflow_d;
    end
  end

  trace_fifo #(
    .DW    (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .flush     (rst || clear),
    .push      (evt),
    .push_data (push_data),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (count)
  );

  assign rd_valid = !fifo_empty;
  assign overflow = overflow_q;

endmodule

// File: doc/skeleton_trace_capture.md
Name: skeleton_trace_capture

Overview:
Hardware-side capture monitor for the three-output skeleton design. It sits on the DUT outputs (d, e, f) and records every value change with a cycle timestamp into an internal buffer. A downstream reader drains the buffer through a valid/ready port. It is the receiving end of the stimulus/response path, so flow-tracking experiments can check recorded output traces against the applied stimulus without a simulator dump.

Parameters:
W, 3, width of the sampled vector (bit 2 = d, bit 1 = e, bit 0 = f)
TS_W, 16, timestamp counter width
DEPTH, 8, event buffer entries; power of two, >= 2

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous, active-high reset
en  input  1  capture enable; timestamp counts and changes are recorded only while high
clear  input  1  synchronous clear of buffer, overflow flag and timestamp (same effect as rst)
sample  input  W  DUT output vector, sampled every clock
rd_valid  output  1  buffer non-empty; rd_data holds the oldest entry
rd_ready  input  1  reader accepts rd_data when rd_valid && rd_ready
rd_data  output  1+TS_W+W  {wrap, timestamp, value}
count  output  $clog2(DEPTH)+1  entries currently stored
overflow  output  1  sticky: at least one event was dropped

Behaviour:
- Reset (rst or clear, checked on the clock edge): rd_valid=0, rd_data=0, count=0, overflow=0, timestamp=0, wrap_pending=0, prev_valid=0. rst has priority over all other inputs.
- Timestamp: TS_W-bit counter. It increments each cycle en=1 and holds when en=0. It wraps from all-ones to 0. On wrap, wrap_pending is set.
- Event detect, in a cycle with en=1:
  - the event fires if prev_valid=0 (first enabled sample) or sample != prev_sample;
  - then prev_sample<=sample and prev_valid<=1.
  - With en=0, no events fire and prev_* hold.
- Entry content: {wrap_pending, timestamp value in the detect cycle, sample}. After a push, wrap_pending clears. If the wrap and the push happen in the same cycle, the entry's wrap bit = 1 and wrap_pending stays 0.
- Latency: an event detected in cycle N is visible on rd_valid/rd_data from cycle N+1.
- Buffer: circular FIFO with first-word fall-through. rd_data is the head entry whenever rd_valid=1; it is 0 when empty. Pop happens on rd_valid && rd_ready.
- Full (count==DEPTH):
  - push without a same-cycle pop → entry dropped, overflow<=1, wrap_pending preserved;
  - push with a same-cycle pop → both happen and count stays DEPTH.
- Empty: a pop is impossible (rd_valid=0). A push into an empty buffer appears next cycle; there is no same-cycle bypass.
- Pointers are $clog2(DEPTH) bits and wrap naturally. count is updated as +1/-1/0.
- overflow clears only on rst or clear.
- Reset mid-operation: all stored entries are discarded, and the first enabled cycle after reset always records an event.
- en falling does not flush the buffer. Reading continues independently of en.

Decomposition:
- Package skeleton_trace_pkg holds:
  - default constants SKEL_W=3, SKEL_TS_W=16;
  - the entry field offsets (value LSBs, timestamp middle, wrap MSB);
  - a helper function that packs an entry.
- One sub-module: trace_fifo, a generic FWFT circular buffer with push/full/pop/empty/count. Change detection, timestamp and overflow logic stay in the top module.

Test Plan:
- Reset then en=1, sample held at 3'b100 for 5 cycles → exactly one entry {0, ts=0, 100}; count=1; rd_valid rises the cycle after the first enabled edge.
- With rd_ready=0, sample sequence 100, 001, 011, 001 on consecutive enabled cycles → 4 entries. Reading them returns values 100, 001, 011, 001 with timestamps 0, 1, 2, 3.
- DEPTH=8, rd_ready=0, sample toggles every cycle for 10 cycles → count=8, overflow=1, and the first 8 entries are intact. Then assert rd_ready with toggling continuing → one push and one pop per cycle, count stays 8.
- TS_W=4, en=1, sample changes at cycle 17 → recorded entry has wrap=1, ts=1. The next change at cycle 18 → wrap=0.
- en=0 while sample changes 000→111→000 → no entries and timestamp frozen. Then en=1 with sample=000 equal to the last enabled sample → no event.
- Buffer holding 3 entries with overflow=1, pulse clear for 1 cycle → count=0, rd_valid=0, overflow=0. The next enabled cycle records with ts=0.
